ahb_out_arb: RTL

AHB_OUT_ARB -- requirements
Module: ahb_out_arb

---
 rtl/ahb_mtx_pkg.sv | 37 +++
 rtl/ahb_burst_track.sv | 62 ++++++
 rtl/ahb_out_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ahb_mtx_pkg.sv
// Shared AHB matrix encodings: HTRANS/HBURST values, arbitration modes and burst-length decode.
package ahb_mtx_pkg;

   typedef enum logic [1:0] {
      HtransIdle   = 2'b00,
      HtransBusy   = 2'b01,
      HtransNonseq = 2'b10,
      HtransSeq    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HburstSingle = 3'b000,
      HburstIncr   = 3'b001,
      HburstWrap4  = 3'b010,
      HburstIncr4  = 3'b011,
      HburstWrap8  = 3'b100,
      HburstIncr8  = 3'b101,
      HburstWrap16 = 3'b110,
      HburstIncr16 = 3'b111
   } hburst_e;

   localparam int unsigned ArbFixed      = 0;
   localparam int unsigned ArbRoundRobin = 1;

   // Remaining SEQ beats after the NONSEQ of a fixed-length burst; 0 for undefined length.
   function automatic logic [3:0] burst_load(input logic [2:0] hburst);
      logic [3:0] load;
      case (hburst)
         HburstWrap16, HburstIncr16: load = 4'd15;
         HburstWrap8,  HburstIncr8:  load = 4'd7;
         HburstWrap4,  HburstIncr4:  load = 4'd3;
         default:                    load = 4'd0;
      endcase
      return load;
   endfunction

endpackage

// File: rtl/ahb_burst_track.sv
// Tracks fixed-length bursts on the output port and raises hold until the final beat completes.
module ahb_burst_track
   import ahb_mtx_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       HREADYM,
   input  logic       HSELM,
   input  logic [1:0] HTRANSM,
   input  logic [2:0] HBURSTM,
   output logic       next_hold,
   output logic       reg_hold
);

   logic [3:0] cnt_q, cnt_d;
   logic       hold_q, hold_d;

   always_comb begin
      cnt_d  = cnt_q;
      hold_d = hold_q;
      if (HREADYM) begin
         if (!HSELM) begin
            cnt_d  = '0;
            hold_d = 1'b0;
         end else begin
            case (HTRANSM)
               HtransNonseq: begin
                  cnt_d  = burst_load(HBURSTM);
                  hold_d = (burst_load(HBURSTM) != 4'd0);
               end
               HtransSeq: begin
                  // The beat completing with one left is the last one of the burst.
                  hold_d = hold_q & (cnt_q != 4'd1);
                  if (cnt_q != 4'd0) begin
                     cnt_d = cnt_q - 4'd1;
                  end
               end
               HtransBusy: begin
               end
               default: begin
                  cnt_d  = '0;
                  hold_d = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         cnt_q  <= '0;
         hold_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
      end
   end

   assign next_hold = hold_d;
   assign reg_hold  = hold_q;

endmodule

// File: rtl/ahb_out_arb.sv
// Output-port arbiter: picks which input port owns the output, honouring bursts and locks.
module ahb_out_arb
   import ahb_mtx_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned PORT_W    = 3,
   parameter int unsigned ARB_MODE  = ArbFixed
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_in_port,
   output logic                 no_port
);

   localparam int unsigned IdxW = PORT_W + 1;

   logic [PORT_W-1:0]    port_q, port_nxt, last_q;
   logic                 nop_q, nop_nxt;
   logic                 next_hold, reg_hold, unused_reg_hold;
   logic [NUM_PORTS-1:0] eff;

   logic                 fp_found;
   logic [PORT_W-1:0]    fp_idx;
   logic                 rr_found;
   logic [PORT_W-1:0]    rr_idx;
   logic [IdxW-1:0]      rr_start, rr_off, rr_sum;
   logic [NUM_PORTS-1:0] rr_rot;
   logic                 sel_found, from_search;
   logic [PORT_W-1:0]    sel_idx;

   ahb_burst_track u_burst_track (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HREADYM   (HREADYM),
      .HSELM     (HSELM),
      .HTRANSM   (HTRANSM),
      .HBURSTM   (HBURSTM),
      .next_hold (next_hold),
      .reg_hold  (reg_hold)
   );

   assign unused_reg_hold = reg_hold;

   // The port currently driving a live transfer keeps requesting implicitly.
   always_comb begin
      eff = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         eff[i] = req[i] | ((port_q == PORT_W'(i)) & HSELM & (HTRANSM != HtransIdle));
      end
   end

   always_comb begin
      fp_found = 1'b0;
      fp_idx   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!fp_found && eff[i]) begin
            fp_found = 1'b1;
            fp_idx   = PORT_W'(i);
         end
      end
   end

   // Rotate eff so the port after last_grant sits at bit 0, then take the lowest set bit.
   always_comb begin
      rr_start = (last_q >= PORT_W'(NUM_PORTS - 1)) ? '0 : (IdxW'(last_q) + IdxW'(1));
      rr_rot   = NUM_PORTS'({eff, eff} >> rr_start);
      rr_found = 1'b0;
      rr_off   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!rr_found && rr_rot[k]) begin
            rr_found = 1'b1;
            rr_off   = IdxW'(k);
         end
      end
      rr_sum = rr_start + rr_off;
      if (rr_sum >= IdxW'(NUM_PORTS)) begin
         rr_sum = rr_sum - IdxW'(NUM_PORTS);
      end
      rr_idx = PORT_W'(rr_sum);
   end

   always_comb begin
      if (ARB_MODE == ArbRoundRobin) begin
         sel_found = rr_found;
         sel_idx   = rr_idx;
      end else begin
         sel_found = fp_found;
         sel_idx   = fp_idx;
      end
   end

   always_comb begin
      port_nxt    = port_q;
      nop_nxt     = 1'b1;
      from_search = 1'b0;
      if (HMASTLOCKM || next_hold) begin
         nop_nxt = 1'b0;
      end else if (sel_found) begin
         port_nxt    = sel_idx;
         nop_nxt     = 1'b0;
         from_search = 1'b1;
      end else if (HSELM) begin
         nop_nxt = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         port_q <= '0;
         nop_q  <= 1'b1;
         last_q <= PORT_W'(NUM_PORTS - 1);
      end else if (HREADYM) begin
         port_q <= port_nxt;
         nop_q  <= nop_nxt;
         if (from_search) begin
            last_q <= sel_idx;
         end
      end
   end

   assign addr_in_port = port_q;
   assign no_port      = nop_q;

endmodule
